// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter: FSM state encoding and
// the cache-line data type.
package lc3b_mem_arbiter_pkg;

  localparam int unsigned LINE_WIDTH = 128;

  typedef logic [LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } lc3b_arb_state;

  // Plain-vector views of the enum for the legacy-compatible state register.
  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_BUSY = ARB_BUSY;
  localparam logic [1:0] ST_DONE = ARB_DONE;

endpackage

// File: rtl/lc3b_rr_picker.sv
// Combinational winner selection: first active port scanning upward from ptr
// with wrap-around; fixed priority is the same search started at port 0.
module lc3b_rr_picker #(
  parameter int NUM_PORTS  = 2,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] active,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     index,
  output logic                 valid
);

  logic [PTR_W-1:0]     base;
  logic [NUM_PORTS-1:0] rot;
  logic [PTR_W-1:0]     offset;
  logic [PTR_W:0]       sum;

  assign base = FIXED_PRIO ? '0 : ptr;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    grant  = '0;
    offset = '0;
    valid  = |active;
    // Rotate so bit 0 is the port at base; the lowest set bit is the winner.
    rot = NUM_PORTS'({active, active} >> base);
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (rot[j]) offset = PTR_W'(j);
    end
    sum   = {1'b0, base} + {1'b0, offset};
    index = (sum >= (PTR_W + 1)'(NUM_PORTS)) ? PTR_W'(sum - (PTR_W + 1)'(NUM_PORTS))
                                             : PTR_W'(sum);
    grant[index] = valid;
  end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// N-port arbiter multiplexing cache-line requests onto the single LC-3b
// physical-memory port; one outstanding transaction, all outputs registered.
module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = int'(LINE_WIDTH),
  parameter int FIXED_PRIO = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 req_read,
  input  logic [NUM_PORTS-1:0]                 req_write,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                 req_resp,
  output logic [DATA_WIDTH-1:0]                req_rdata,
  output logic                                 pmem_read,
  output logic                                 pmem_write,
  output logic [ADDR_WIDTH-1:0]                pmem_address,
  output logic [DATA_WIDTH-1:0]                pmem_wdata,
  input  logic                                 pmem_resp,
  input  logic [DATA_WIDTH-1:0]                pmem_rdata
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [1:0]           state;
  logic [PTR_W-1:0]     ptr;
  logic [NUM_PORTS-1:0] owner;
  logic [NUM_PORTS-1:0] active;
  logic [NUM_PORTS-1:0] win_oh;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_valid;

  assign active = req_read | req_write;

  lc3b_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .FIXED_PRIO(FIXED_PRIO != 0)
  ) u_picker (
    .active(active),
    .ptr   (ptr),
    .grant (win_oh),
    .index (win_idx),
    .valid (win_valid)
  );

  // NOTE: reset is synchronous, so rst_n is simply sampled at the edge here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner        <= '0;
      req_resp     <= '0;
      req_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            owner        <= win_oh;
            ptr          <= (win_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
            // Write wins when a client raises both read and write.
            pmem_write   <= req_write[win_idx];
            pmem_read    <= ~req_write[win_idx];
            pmem_address <= req_address[win_idx];
            pmem_wdata   <= req_wdata[win_idx];
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            req_resp   <= owner;
            req_rdata  <= pmem_rdata;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          req_resp <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter: a directed 2-port vector table,
// grant-order sequences on 4-port round-robin/fixed instances, and random traffic.
module tb_lc3b_mem_arbiter;
  import lc3b_mem_arbiter_pkg::*;

  localparam lc3b_line DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam lc3b_line D55  = {16{8'h55}};
  localparam lc3b_line DAA  = {16{8'hAA}};

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // ---------------- 2-port round-robin instance ----------------
  logic [1:0]           d_rd, d_wr, d_resp;
  logic [1:0][15:0]     d_addr;
  logic [1:0][127:0]    d_wdata;
  lc3b_line             d_rdata, d_pwdata, d_prdata;
  logic                 d_pread, d_pwrite, d_presp;
  logic [15:0]          d_paddr;

  lc3b_mem_arbiter #(.NUM_PORTS(2), .FIXED_PRIO(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_read(d_rd), .req_write(d_wr), .req_address(d_addr), .req_wdata(d_wdata),
    .req_resp(d_resp), .req_rdata(d_rdata),
    .pmem_read(d_pread), .pmem_write(d_pwrite), .pmem_address(d_paddr),
    .pmem_wdata(d_pwdata), .pmem_resp(d_presp), .pmem_rdata(d_prdata)
  );

  // ---------------- 4-port instances: [0] round-robin, [1] fixed priority ----------------
  logic [3:0]        q_rd [2], q_wr [2], q_resp [2];
  logic [3:0][15:0]  q_addr [2];
  logic [3:0][127:0] q_wdata [2];
  lc3b_line          q_rdata [2], p_wdata [2], p_rdata [2];
  logic              p_read [2], p_write [2], p_resp [2];
  logic [15:0]       p_addr [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_quad
    lc3b_mem_arbiter #(.NUM_PORTS(4), .FIXED_PRIO(gi)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_read(q_rd[gi]), .req_write(q_wr[gi]), .req_address(q_addr[gi]),
      .req_wdata(q_wdata[gi]), .req_resp(q_resp[gi]), .req_rdata(q_rdata[gi]),
      .pmem_read(p_read[gi]), .pmem_write(p_write[gi]), .pmem_address(p_addr[gi]),
      .pmem_wdata(p_wdata[gi]), .pmem_resp(p_resp[gi]), .pmem_rdata(p_rdata[gi])
    );
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [1:0] rd, wr;
    logic       presp, scramble;
    logic       e_rd, e_wr;
    logic [1:0] e_resp;
    logic [15:0] e_addr;
    lc3b_line   e_rdata, e_wdata;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic r, logic [1:0] rd, logic [1:0] wr, logic presp, logic scr,
                              logic erd, logic ewr, logic [1:0] eresp, logic [15:0] eaddr,
                              lc3b_line erdata, lc3b_line ewdata);
    vec_t v;
    v.rst_n = r; v.rd = rd; v.wr = wr; v.presp = presp; v.scramble = scr;
    v.e_rd = erd; v.e_wr = ewr; v.e_resp = eresp; v.e_addr = eaddr;
    v.e_rdata = erdata; v.e_wdata = ewdata;
    return v;
  endfunction

  task automatic run_table();
    vecs[0]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[1]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[2]  = mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[3]  = mk(1, 2'b11, 2'b00, 0, 0, 1, 0, 2'b00, 16'h0040, '0, '0);
    vecs[4]  = mk(1, 2'b11, 2'b00, 1, 0, 0, 0, 2'b01, 16'h0000, DEAD, '0);
    vecs[5]  = mk(1, 2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[6]  = mk(1, 2'b10, 2'b00, 0, 0, 1, 0, 2'b00, 16'h1230, '0, '0);
    vecs[7]  = mk(1, 2'b10, 2'b00, 0, 0, 1, 0, 2'b00, 16'h1230, '0, '0);
    vecs[8]  = mk(1, 2'b10, 2'b00, 0, 1, 1, 0, 2'b00, 16'h1230, '0, '0);
    vecs[9]  = mk(1, 2'b10, 2'b00, 0, 0, 1, 0, 2'b00, 16'h1230, '0, '0);
    vecs[10] = mk(1, 2'b10, 2'b00, 1, 0, 0, 0, 2'b10, 16'h0000, DEAD, '0);
    vecs[11] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[12] = mk(1, 2'b01, 2'b01, 0, 0, 0, 1, 2'b00, 16'h0040, '0, D55);
    vecs[13] = mk(1, 2'b01, 2'b01, 1, 0, 0, 0, 2'b01, 16'h0000, DEAD, '0);
    vecs[14] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[15] = mk(1, 2'b11, 2'b00, 0, 0, 1, 0, 2'b00, 16'h1230, '0, '0);
    vecs[16] = mk(1, 2'b11, 2'b00, 1, 0, 0, 0, 2'b10, 16'h0000, DEAD, '0);
    vecs[17] = mk(1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[18] = mk(1, 2'b01, 2'b00, 0, 0, 1, 0, 2'b00, 16'h0040, '0, '0);
    vecs[19] = mk(1, 2'b01, 2'b00, 0, 0, 1, 0, 2'b00, 16'h0040, '0, '0);
    vecs[20] = mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    vecs[21] = mk(1, 2'b11, 2'b00, 0, 0, 1, 0, 2'b00, 16'h0040, '0, '0);
    vecs[22] = mk(1, 2'b11, 2'b00, 1, 0, 0, 0, 2'b01, 16'h0000, DEAD, '0);
    vecs[23] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 16'h0000, '0, '0);
    for (int i = 0; i < 24; i++) begin
      rst_n      = vecs[i].rst_n;
      d_rd       = vecs[i].rd;
      d_wr       = vecs[i].wr;
      d_presp    = vecs[i].presp;
      d_addr[1]  = vecs[i].scramble ? 16'hFFFF : 16'h1230;
      d_wdata[1] = vecs[i].scramble ? '1 : DAA;
      @(posedge clk); #1;
      check($sformatf("vec%0d pmem_read", i), d_pread, vecs[i].e_rd);
      check($sformatf("vec%0d pmem_write", i), d_pwrite, vecs[i].e_wr);
      check($sformatf("vec%0d req_resp", i), d_resp, vecs[i].e_resp);
      if (vecs[i].e_rd || vecs[i].e_wr || !vecs[i].rst_n)
        check($sformatf("vec%0d pmem_address", i), d_paddr, vecs[i].e_addr);
      if (vecs[i].e_wr || !vecs[i].rst_n)
        check($sformatf("vec%0d pmem_wdata", i), d_pwdata, vecs[i].e_wdata);
      if (vecs[i].e_resp != 0 || !vecs[i].rst_n)
        check($sformatf("vec%0d req_rdata", i), d_rdata, vecs[i].e_rdata);
    end
  endtask

  // ---------------- grant-order sequences ----------------
  task automatic serve_seq(input int inst, input logic [3:0] start, input int reraise_in [4],
                           input int n, input int exp_order [5], input string tag);
    int reraise [4];
    logic [3:0] pend, prev_resp;
    int got, idx;
    reraise = reraise_in;
    pend = '0; prev_resp = '0; got = 0; idx = 0;
    q_rd[inst] = start; q_wr[inst] = '0; p_resp[inst] = 1'b1;
    for (int c = 0; c < 40 * n && got < n; c++) begin
      @(posedge clk); #1;
      q_rd[inst] = q_rd[inst] | pend;
      pend = '0;
      if (q_resp[inst] != 0) begin
        check($sformatf("%s resp single-cycle", tag), prev_resp, 4'b0000);
        check($sformatf("%s resp one-hot", tag), $onehot(q_resp[inst]), 1'b1);
        for (int p = 3; p >= 0; p--) if (q_resp[inst][p]) idx = p;
        check($sformatf("%s grant #%0d", tag, got), idx, exp_order[got]);
        q_rd[inst][idx] = 1'b0;
        if (reraise[idx] > 0) begin
          reraise[idx]--;
          pend[idx] = 1'b1;
        end
        got++;
      end
      prev_resp = q_resp[inst];
    end
    check($sformatf("%s responses within budget", tag), got, n);
    q_rd[inst] = '0; p_resp[inst] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // ---------------- random traffic against a transaction-level model ----------------
  function automatic int pick(input logic [3:0] act, input int base);
    for (int k = 0; k < 4; k++)
      if (act[(base + k) % 4]) return (base + k) % 4;
    return 0;
  endfunction

  task automatic run_random(input int inst, input int cycles);
    int phase;  // 0: arbiter free, 1: memory transfer in flight, 2: response cycle
    int ptr, owner;
    logic own_wr;
    logic [15:0] own_addr;
    lc3b_line own_wdata, exp_rdata;
    logic [3:0] act_b, wr_b, exp_resp;
    logic [3:0][15:0] addr_b;
    logic [3:0][127:0] wdata_b;
    logic resp_b;
    lc3b_line rdata_b;
    string tag;
    phase = 0; ptr = 0; owner = 0; own_wr = 0; own_addr = '0; own_wdata = '0; exp_rdata = '0;
    tag = (inst == 0) ? "rr" : "fixed";
    q_rd[inst] = '0; q_wr[inst] = '0; p_resp[inst] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      act_b = q_rd[inst] | q_wr[inst]; wr_b = q_wr[inst];
      addr_b = q_addr[inst]; wdata_b = q_wdata[inst];
      resp_b = p_resp[inst]; rdata_b = p_rdata[inst];
      @(posedge clk); #1;
      exp_resp = '0;
      if (phase == 0) begin
        if (act_b != 0) begin
          owner = pick(act_b, (inst == 1) ? 0 : ptr);
          ptr = (owner + 1) % 4;
          own_wr = wr_b[owner]; own_addr = addr_b[owner]; own_wdata = wdata_b[owner];
          phase = 1;
        end
      end else if (phase == 1) begin
        if (resp_b) begin
          exp_resp[owner] = 1'b1;
          exp_rdata = rdata_b;
          phase = 2;
        end
      end else begin
        phase = 0;
      end
      check($sformatf("%s cyc%0d pmem_read", tag, c), p_read[inst], phase == 1 && !own_wr);
      check($sformatf("%s cyc%0d pmem_write", tag, c), p_write[inst], phase == 1 && own_wr);
      check($sformatf("%s cyc%0d req_resp", tag, c), q_resp[inst], exp_resp);
      if (phase == 1) begin
        check($sformatf("%s cyc%0d pmem_address", tag, c), p_addr[inst], own_addr);
        if (own_wr) check($sformatf("%s cyc%0d pmem_wdata", tag, c), p_wdata[inst], own_wdata);
      end
      if (phase == 2) check($sformatf("%s cyc%0d req_rdata", tag, c), q_rdata[inst], exp_rdata);
      for (int p = 0; p < 4; p++) begin
        if (q_resp[inst][p]) begin
          q_rd[inst][p] = 1'b0; q_wr[inst][p] = 1'b0;
        end else if (!(q_rd[inst][p] || q_wr[inst][p])) begin
          if ($urandom_range(3) == 0) begin
            case ($urandom_range(2))
              0:       q_rd[inst][p] = 1'b1;
              1:       q_wr[inst][p] = 1'b1;
              default: begin q_rd[inst][p] = 1'b1; q_wr[inst][p] = 1'b1; end
            endcase
            q_addr[inst][p]  = {4'(p), 12'($urandom)};
            q_wdata[inst][p] = {$urandom, $urandom, $urandom, $urandom};
          end
        end else if (phase == 1 && p == owner && $urandom_range(15) == 0) begin
          q_rd[inst][p] = 1'b0; q_wr[inst][p] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          q_addr[inst][p]  = 16'($urandom);
          q_wdata[inst][p] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      p_resp[inst]  = (phase == 1) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      p_rdata[inst] = {$urandom, $urandom, $urandom, $urandom};
    end
    q_rd[inst] = '0; q_wr[inst] = '0; p_resp[inst] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_re [4], rr_exp [5], fx_re [4], fx_exp [5];
    rst_n = 1'b0;
    d_rd = '0; d_wr = '0; d_presp = 1'b0; d_prdata = DEAD;
    d_addr[0] = 16'h0040; d_addr[1] = 16'h1230;
    d_wdata[0] = D55; d_wdata[1] = DAA;
    for (int i = 0; i < 2; i++) begin
      q_rd[i] = '0; q_wr[i] = '0; p_resp[i] = 1'b0; p_rdata[i] = '0;
      for (int p = 0; p < 4; p++) begin
        q_addr[i][p]  = {4'(p), 12'h000};
        q_wdata[i][p] = '0;
      end
    end

    run_table();

    rr_re  = '{1, 1, 1, 1};
    rr_exp = '{0, 1, 2, 3, 0};
    serve_seq(0, 4'b1111, rr_re, 5, rr_exp, "rr order");

    fx_re  = '{2, 0, 0, 0};
    fx_exp = '{0, 0, 0, 2, 0};
    serve_seq(1, 4'b0101, fx_re, 4, fx_exp, "fixed order");

    run_random(0, 700);
    run_random(1, 700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
